// File: rtl/exc_ctrl.sv
// exc_ctrl: precise-exception and interrupt controller at the memory stage.
// Picks one event from the M instruction (or a pending interrupt), writes it
// into CP0 with a held request/ready handshake, then issues a one-cycle
// flush + redirect and masks interrupts for a short settle window.

package exc_ctrl_pkg;

    typedef enum logic [1:0] {
        CP0_NONE  = 2'd0,
        CP0_EXC   = 2'd1,
        CP0_BADVA = 2'd2,
        CP0_ERET  = 2'd3
    } cp0_op_t;

    typedef struct packed {
        logic [31:0] epc;
        logic        cause_bd;
        logic [4:0]  cause_exccode;
        logic [31:0] badvaddr;
    } exc_info_t;

endpackage

// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | watching M for exceptions/ERET and pending interrupts
// WRITE  | cp0_wen held with latched wtype/exc_info until cp0_ready
// REDIR  | single cycle of flush + redirect_valid
// SETTLE | counter runs down; M flags and interrupts ignored
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_in_ds,
    input  logic        m_adel_if,
    input  logic        m_ri,
    input  logic        m_ov,
    input  logic        m_sys,
    input  logic        m_bp,
    input  logic        m_adel_ld,
    input  logic        m_ades_st,
    input  logic        m_eret,
    input  logic [31:0] m_badvaddr,
    input  logic [31:0] status,
    input  logic [31:0] cause,
    input  logic [31:0] epc,
    input  logic        cp0_ready,
    output logic        cp0_wen,
    output cp0_op_t     cp0_wtype,
    output exc_info_t   exc_info,
    output logic        m_stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_REDIR  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [7:0] LP_SETTLE = 8'(SETTLE_CYCLES);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_wen;
    cp0_op_t     r_wtype;
    exc_info_t   r_info;
    logic        r_flush;
    logic        r_redir_valid;
    logic        r_is_eret;

    logic        w_int_req;
    logic        w_hit;
    cp0_op_t     w_wtype;
    logic [4:0]  w_code;
    logic [31:0] w_badva;
    logic [31:0] w_epc;
    logic        w_event;
    logic        w_unused;

    // Interrupts are only sampled once the settle window has fully expired,
    // so stale status/cause from before the redirect cannot retrigger.
    assign w_int_req = status[0] & ~status[1]
                     & (|(status[15:8] & cause[15:8]))
                     & (r_cnt == 8'd0);

    // An interrupted instruction does not retire, so EPC names it directly;
    // a delay-slot instruction reports its branch instead.
    assign w_epc = m_in_ds ? (m_pc - 32'd4) : m_pc;

    // Fixed-priority pick of the single event reported for the M instruction.
    always_comb begin
        w_hit   = 1'b0;
        w_wtype = CP0_NONE;
        w_code  = 5'd0;
        w_badva = 32'd0;
        if (m_valid) begin
            if (w_int_req) begin
                w_hit   = 1'b1;
                w_wtype = CP0_EXC;
                w_code  = 5'd0;
            end else if (m_adel_if) begin
                w_hit   = 1'b1;
                w_wtype = CP0_BADVA;
                w_code  = 5'd4;
                w_badva = m_pc;
            end else if (m_ri) begin
                w_hit   = 1'b1;
                w_wtype = CP0_EXC;
                w_code  = 5'd10;
            end else if (m_ov) begin
                w_hit   = 1'b1;
                w_wtype = CP0_EXC;
                w_code  = 5'd12;
            end else if (m_sys) begin
                w_hit   = 1'b1;
                w_wtype = CP0_EXC;
                w_code  = 5'd8;
            end else if (m_bp) begin
                w_hit   = 1'b1;
                w_wtype = CP0_EXC;
                w_code  = 5'd9;
            end else if (m_adel_ld) begin
                w_hit   = 1'b1;
                w_wtype = CP0_BADVA;
                w_code  = 5'd4;
                w_badva = m_badvaddr;
            end else if (m_ades_st) begin
                w_hit   = 1'b1;
                w_wtype = CP0_BADVA;
                w_code  = 5'd5;
                w_badva = m_badvaddr;
            end else if (m_eret) begin
                w_hit   = 1'b1;
                w_wtype = CP0_ERET;
                w_code  = 5'd0;
            end
        end
    end

    // Gated by resetn so the stall drops together with the async reset.
    assign w_event = resetn & (r_state == ST_IDLE) & w_hit;

    // Main sequencer: latch the event, hold the CP0 request, pulse the
    // redirect, then run the settle counter down.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_wen         <= 1'b0;
            r_wtype       <= CP0_NONE;
            r_info        <= '0;
            r_flush       <= 1'b0;
            r_redir_valid <= 1'b0;
            r_is_eret     <= 1'b0;
        end else begin
            r_flush       <= 1'b0;
            r_redir_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        r_state   <= ST_WRITE;
                        r_wen     <= 1'b1;
                        r_wtype   <= w_wtype;
                        r_info    <= '{epc:           w_epc,
                                       cause_bd:      m_in_ds,
                                       cause_exccode: w_code,
                                       badvaddr:      w_badva};
                        r_is_eret <= (w_wtype == CP0_ERET);
                    end
                end
                ST_WRITE: begin
                    if (cp0_ready) begin
                        r_state       <= ST_REDIR;
                        r_wen         <= 1'b0;
                        r_wtype       <= CP0_NONE;
                        r_flush       <= 1'b1;
                        r_redir_valid <= 1'b1;
                    end
                end
                ST_REDIR: begin
                    r_state <= ST_SETTLE;
                    r_cnt   <= LP_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt <= 8'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // ERET returns to the EPC that CP0 presents during the redirect cycle,
    // so that target is taken live rather than latched earlier.
    assign redirect_pc = r_redir_valid ? (r_is_eret ? epc : EXC_VECTOR) : 32'd0;

    assign cp0_wen        = r_wen;
    assign cp0_wtype      = r_wtype;
    assign exc_info       = r_info;
    assign flush          = r_flush;
    assign redirect_valid = r_redir_valid;
    assign m_stall        = resetn & ((r_state != ST_IDLE) | w_event);

    assign w_unused = ^{status[31:16], status[7:2], cause[31:16], cause[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: event-timestamp reference model plus directed cases.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    localparam logic [31:0] VEC    = 32'hBFC0_0380;
    localparam int          SETTLE = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m_valid, m_in_ds;
    logic        m_adel_if, m_ri, m_ov, m_sys, m_bp, m_adel_ld, m_ades_st, m_eret;
    logic [31:0] m_pc, m_badvaddr, status, cause, epc;
    logic        cp0_ready;
    logic        cp0_wen;
    cp0_op_t     cp0_wtype;
    exc_info_t   exc_info;
    logic        m_stall, flush, redirect_valid;
    logic [31:0] redirect_pc;

    exc_ctrl #(.EXC_VECTOR(VEC), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_pc(m_pc), .m_in_ds(m_in_ds),
        .m_adel_if(m_adel_if), .m_ri(m_ri), .m_ov(m_ov), .m_sys(m_sys), .m_bp(m_bp),
        .m_adel_ld(m_adel_ld), .m_ades_st(m_ades_st), .m_eret(m_eret),
        .m_badvaddr(m_badvaddr), .status(status), .cause(cause), .epc(epc),
        .cp0_ready(cp0_ready), .cp0_wen(cp0_wen), .cp0_wtype(cp0_wtype),
        .exc_info(exc_info), .m_stall(m_stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model: timestamps of the current transaction
    int        cyc = 0;
    bit        busy = 0;
    int        t0 = 0;
    int        t_rdy = -1;
    int        lat = 3;
    int        force_lat = 3;
    cp0_op_t   mwt;
    exc_info_t minf;
    bit        mer;

    // observations of DUT behaviour used by the literal pins
    int        obs_req, obs_wen_cnt, obs_flush_cnt;
    exc_info_t obs_info;
    cp0_op_t   obs_wt;
    logic [31:0] obs_rpc;
    bit        prev_wen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decode: first flag in priority order wins.
    function automatic void decode(output bit evt, output cp0_op_t wt,
                                   output exc_info_t inf, output bit is_eret);
        bit          fl[8];
        int          code[8] = '{0, 4, 10, 12, 8, 9, 4, 5};
        bit          intr;
        intr = status[0] && !status[1] && ((status[15:8] & cause[15:8]) != 8'h0);
        fl = '{intr, m_adel_if, m_ri, m_ov, m_sys, m_bp, m_adel_ld, m_ades_st};
        evt = 0; wt = CP0_NONE; inf = '0; is_eret = 0;
        if (!m_valid) return;
        inf.epc      = m_in_ds ? m_pc - 32'd4 : m_pc;
        inf.cause_bd = m_in_ds;
        for (int i = 0; i < 8; i++) begin
            if (fl[i]) begin
                evt = 1;
                inf.cause_exccode = 5'(code[i]);
                wt = (i == 1 || i == 6 || i == 7) ? CP0_BADVA : CP0_EXC;
                inf.badvaddr = (i == 1) ? m_pc : ((i >= 6) ? m_badvaddr : 32'd0);
                return;
            end
        end
        if (m_eret) begin
            evt = 1; wt = CP0_ERET; is_eret = 1;
        end
    endfunction

    // One clock: entered and left at posedge+1 with inputs already set.
    task automatic cycle();
        bit        evt, er, exp_wen, exp_fl;
        cp0_op_t   wt;
        exc_info_t inf;
        if (busy && t_rdy >= 0 && cyc >= t_rdy + 2 + SETTLE) busy = 0;
        cp0_ready = busy && t_rdy < 0 && (cyc - t0) == lat;
        if (cp0_ready) t_rdy = cyc;
        #1;
        decode(evt, wt, inf, er);
        if (!busy) begin
            chk("stall_idle", m_stall, evt);
            chk("wen_idle", cp0_wen, 0);
            chk("wtype_idle", cp0_wtype, CP0_NONE);
            chk("flush_idle", flush, 0);
            chk("rv_idle", redirect_valid, 0);
        end else begin
            exp_wen = cyc > t0 && (t_rdy < 0 || cyc <= t_rdy);
            exp_fl  = t_rdy >= 0 && cyc == t_rdy + 1;
            chk("stall_busy", m_stall, 1);
            chk("wen", cp0_wen, exp_wen);
            chk("wtype", cp0_wtype, exp_wen ? mwt : CP0_NONE);
            if (exp_wen) begin
                chk("info_epc", exc_info.epc, minf.epc);
                chk("info_bd", exc_info.cause_bd, minf.cause_bd);
                chk("info_code", exc_info.cause_exccode, minf.cause_exccode);
                chk("info_badva", exc_info.badvaddr, minf.badvaddr);
            end
            chk("flush", flush, exp_fl);
            chk("redirect_valid", redirect_valid, exp_fl);
            chk("redirect_pc", redirect_pc, exp_fl ? (mer ? epc : VEC) : 32'd0);
        end
        if (cp0_wen) begin
            obs_wen_cnt++; obs_info = exc_info; obs_wt = cp0_wtype;
            if (!prev_wen) obs_req++;
        end
        prev_wen = cp0_wen;
        if (flush) begin obs_flush_cnt++; obs_rpc = redirect_pc; end
        if (!busy && evt) begin
            busy = 1; t0 = cyc; t_rdy = -1; mwt = wt; minf = inf; mer = er;
            lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 5));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        m_valid = 0; m_in_ds = 0; m_pc = 0; m_badvaddr = 0;
        m_adel_if = 0; m_ri = 0; m_ov = 0; m_sys = 0; m_bp = 0;
        m_adel_ld = 0; m_ades_st = 0; m_eret = 0;
        status = 0; cause = 0; epc = 0;
    endtask

    task automatic clear_flags();
        m_adel_if = 0; m_ri = 0; m_ov = 0; m_sys = 0; m_bp = 0;
        m_adel_ld = 0; m_ades_st = 0; m_eret = 0;
    endtask

    task automatic clear_obs();
        obs_req = 0; obs_wen_cnt = 0; obs_flush_cnt = 0;
        obs_info = '0; obs_wt = CP0_NONE; obs_rpc = 0;
    endtask

    // Event on the first cycle only, then enough quiet cycles to return to IDLE.
    task automatic run_txn();
        clear_obs();
        cycle();
        clear_flags();
        repeat (9) cycle();
    endtask

    task automatic rand_inputs();
        m_valid    = ($urandom_range(0, 3) != 0);
        m_in_ds    = 1'($urandom_range(0, 1));
        m_pc       = $urandom;
        m_badvaddr = $urandom;
        epc        = $urandom;
        m_adel_if  = ($urandom_range(0, 11) == 0);
        m_ri       = ($urandom_range(0, 11) == 0);
        m_ov       = ($urandom_range(0, 11) == 0);
        m_sys      = ($urandom_range(0, 11) == 0);
        m_bp       = ($urandom_range(0, 11) == 0);
        m_adel_ld  = ($urandom_range(0, 11) == 0);
        m_ades_st  = ($urandom_range(0, 11) == 0);
        m_eret     = ($urandom_range(0, 7) == 0);
        status     = $urandom;
        cause      = ($urandom & 32'hFFFF_00FF)
                   | (($urandom_range(0, 2) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0);
    endtask

    initial begin
        clear_inputs();
        cp0_ready = 0;
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wen", cp0_wen, 0);
        chk("rst_wtype", cp0_wtype, CP0_NONE);
        chk("rst_info", exc_info, 70'h0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_stall", m_stall, 0);
        chk("rst_flush", flush, 0);
        @(posedge clk);
        #1;
        resetn = 1;
        repeat (3) cycle();

        // overflow
        force_lat = 3;
        m_valid = 1; m_ov = 1; m_pc = 32'h8000_0100; m_in_ds = 0;
        run_txn();
        chk("ov_wen_cycles", obs_wen_cnt, 3);
        chk("ov_wtype", obs_wt, CP0_EXC);
        chk("ov_code", obs_info.cause_exccode, 12);
        chk("ov_epc", obs_info.epc, 32'h8000_0100);
        chk("ov_bd", obs_info.cause_bd, 0);
        chk("ov_flush_cnt", obs_flush_cnt, 1);
        chk("ov_rpc", obs_rpc, VEC);

        // delay-slot AdEL load
        clear_inputs();
        m_valid = 1; m_adel_ld = 1; m_in_ds = 1; m_pc = 32'h8000_0204; m_badvaddr = 32'h3;
        run_txn();
        chk("adel_wtype", obs_wt, CP0_BADVA);
        chk("adel_code", obs_info.cause_exccode, 4);
        chk("adel_epc", obs_info.epc, 32'h8000_0200);
        chk("adel_bd", obs_info.cause_bd, 1);
        chk("adel_badva", obs_info.badvaddr, 32'h3);

        // priority without and with a pending interrupt
        clear_inputs();
        m_valid = 1; m_ri = 1; m_sys = 1; m_ades_st = 1; m_pc = 32'h8000_0300;
        run_txn();
        chk("prio_ri_code", obs_info.cause_exccode, 10);
        chk("prio_ri_wtype", obs_wt, CP0_EXC);
        clear_inputs();
        m_valid = 1; m_ri = 1; m_sys = 1; m_ades_st = 1; m_pc = 32'h8000_0300;
        status = 32'h0000_0401; cause = 32'h0000_0400;
        cycle();
        clear_flags();
        status = 32'h0000_0403;
        clear_obs();
        obs_info = '1;
        repeat (9) cycle();
        chk("prio_int_code", obs_info.cause_exccode, 0);
        chk("prio_int_badva", obs_info.badvaddr, 0);

        // ERET
        clear_inputs();
        m_valid = 1; m_eret = 1; epc = 32'h8000_1000; m_pc = 32'h8000_0400;
        run_txn();
        chk("eret_wtype", obs_wt, CP0_ERET);
        chk("eret_badva", obs_info.badvaddr, 0);
        chk("eret_rpc", obs_rpc, 32'h8000_1000);

        // settle masking: interrupt pending throughout, EXL rises only at IDLE
        clear_inputs();
        clear_obs();
        m_valid = 1; m_ov = 1; m_pc = 32'h8000_0500;
        status = 32'h0000_0401; cause = 32'h0000_0400;
        cycle();
        clear_flags();
        repeat (6) cycle();
        status = 32'h0000_0403;
        repeat (5) cycle();
        chk("settle_req_count", obs_req, 1);
        chk("settle_flush_count", obs_flush_cnt, 1);

        // reset in the middle of WRITE
        clear_inputs();
        m_valid = 1; m_ov = 1; m_pc = 32'h8000_0600;
        cycle();
        cycle();
        chk("pre_rst_wen", cp0_wen, 1);
        resetn = 0;
        cp0_ready = 0;
        #1;
        chk("midrst_wen", cp0_wen, 0);
        chk("midrst_stall", m_stall, 0);
        chk("midrst_wtype", cp0_wtype, CP0_NONE);
        busy = 0;
        @(posedge clk);
        #1;
        cyc++;
        resetn = 1;
        clear_flags();
        clear_obs();
        repeat (6) cycle();
        chk("post_rst_no_req", obs_req, 0);
        m_ov = 1;
        run_txn();
        chk("post_rst_new_req", obs_req, 1);

        // randomized traffic with variable CP0 latency
        force_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end
        clear_inputs();
        repeat (12) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
